// File: rtl/mid_pipe_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready output stage between NREQ requesters.
// The granted requester's index travels with its data as OutId so results can be routed back.
module mid_pipe_rr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 10,
    parameter int IW   = 2,
    parameter int SW   = 16
) (
    input  logic               Clk,
    input  logic               Rstn,
    input  logic               Clear,
    input  logic [NREQ*DW-1:0] ReqData,
    input  logic [NREQ-1:0]    ReqVld,
    output logic [NREQ-1:0]    ReqRdy,
    output logic [DW-1:0]      OutData,
    output logic [IW-1:0]      OutId,
    output logic               OutVld,
    input  logic               OutRdy,
    output logic [SW-1:0]      StallCnt
);

    logic          load;
    logic          hasWinner;
    logic [IW-1:0] winner;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptrNext;
    logic [DW-1:0] winData;
    logic          hiVld;
    logic [IW-1:0] lowHi;
    logic [IW-1:0] lowAny;

    assign load = (OutRdy | ~OutVld) & ~Clear;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        hiVld     = 1'b0;
        hasWinner = 1'b0;
        lowHi     = '0;
        lowAny    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (ReqVld[i]) begin
                hasWinner = 1'b1;
                lowAny    = IW'(i);
                if (i >= int'(ptr)) begin
                    hiVld = 1'b1;
                    lowHi = IW'(i);
                end
            end
        end
        winner = hiVld ? lowHi : lowAny;
    end

    always_comb begin
        winData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) begin
                winData = ReqData[i*DW +: DW];
            end
        end
    end

    // Explicit wrap keeps ptr below NREQ even when NREQ is not a power of 2.
    assign ptrNext = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

    // Rstn gating keeps every ready low while the block is held in reset.
    always_comb begin
        ReqRdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            ReqRdy[i] = Rstn & load & hasWinner & (winner == IW'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            OutData <= '0;
            OutId   <= '0;
            OutVld  <= 1'b0;
            ptr     <= '0;
        end else if (Clear) begin
            OutVld <= 1'b0;
            ptr    <= '0;
        end else if (load) begin
            OutVld <= hasWinner;
            if (hasWinner) begin
                OutData <= winData;
                OutId   <= winner;
                ptr     <= ptrNext;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            StallCnt <= '0;
        end else if (Clear) begin
            StallCnt <= '0;
        end else if (OutVld && !OutRdy && (StallCnt != '1)) begin
            StallCnt <= StallCnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_mid_pipe_rr_arb.sv
// Directed bench for mid_pipe_rr_arb: a default instance plus an SW=4 instance for saturation.
module tb_mid_pipe_rr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 10;
    localparam int IW   = 2;
    localparam int SW   = 16;

    logic               Clk = 1'b0;
    logic               Rstn;
    logic               Clear;
    logic [NREQ*DW-1:0] ReqData;
    logic [NREQ-1:0]    ReqVld;
    logic [NREQ-1:0]    ReqRdy;
    logic [DW-1:0]      OutData;
    logic [IW-1:0]      OutId;
    logic               OutVld;
    logic               OutRdy;
    logic [SW-1:0]      StallCnt;

    logic [NREQ-1:0]    ReqRdy4;
    logic [DW-1:0]      OutData4;
    logic [IW-1:0]      OutId4;
    logic               OutVld4;
    logic [3:0]         StallCnt4;

    logic [DW-1:0] dataTab [NREQ];
    int checks = 0;
    int errors = 0;

    mid_pipe_rr_arb #(.NREQ(NREQ), .DW(DW), .IW(IW), .SW(SW)) dut (
        .Clk(Clk), .Rstn(Rstn), .Clear(Clear), .ReqData(ReqData), .ReqVld(ReqVld),
        .ReqRdy(ReqRdy), .OutData(OutData), .OutId(OutId), .OutVld(OutVld),
        .OutRdy(OutRdy), .StallCnt(StallCnt)
    );

    mid_pipe_rr_arb #(.NREQ(NREQ), .DW(DW), .IW(IW), .SW(4)) dut4 (
        .Clk(Clk), .Rstn(Rstn), .Clear(Clear), .ReqData(ReqData), .ReqVld(ReqVld),
        .ReqRdy(ReqRdy4), .OutData(OutData4), .OutId(OutId4), .OutVld(OutVld4),
        .OutRdy(OutRdy), .StallCnt(StallCnt4)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rstn   = 1'b0;
        Clear  = 1'b0;
        ReqVld = '0;
        OutRdy = 1'b0;
        @(posedge Clk);
        #3;
        Rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Rstn   = 1'b0;
        Clear  = 1'b0;
        OutRdy = 1'b1;
        ReqVld = 4'b1111;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (OutVld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", OutVld); end
        checks++; if (OutData !== '0) begin errors++; $display("FAIL reset_data got %h exp 000", OutData); end
        checks++; if (OutId !== '0) begin errors++; $display("FAIL reset_id got %0d exp 0", OutId); end
        checks++; if (StallCnt !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", StallCnt); end
        checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", ReqRdy); end
        ReqVld = '0;
        #2;
        Rstn = 1'b1;
        step();
    endtask

    task automatic test_single_and_skip();
        ReqVld = 4'b0100;
        OutRdy = 1'b1;
        #1;
        checks++; if (ReqRdy !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b exp 0100", ReqRdy); end
        step();
        checks++; if (OutVld !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", OutVld); end
        checks++; if (OutData !== 10'h055) begin errors++; $display("FAIL single_data got %h exp 055", OutData); end
        checks++; if (OutId !== 2'd2) begin errors++; $display("FAIL single_id got %0d exp 2", OutId); end
        // ptr is now 3: a lone request from 1 must wrap around to win.
        ReqVld = 4'b0010;
        #1;
        checks++; if (ReqRdy !== 4'b0010) begin errors++; $display("FAIL skip1_rdy got %b exp 0010", ReqRdy); end
        step();
        checks++; if (OutId !== 2'd1) begin errors++; $display("FAIL skip1_id got %0d exp 1", OutId); end
        ReqVld = 4'b0001;
        #1;
        checks++; if (ReqRdy !== 4'b0001) begin errors++; $display("FAIL skip0_rdy got %b exp 0001", ReqRdy); end
        step();
        checks++; if (OutId !== 2'd0) begin errors++; $display("FAIL skip0_id got %0d exp 0", OutId); end
        checks++; if (OutData !== 10'h111) begin errors++; $display("FAIL skip0_data got %h exp 111", OutData); end
        ReqVld = '0;
        step();
        checks++; if (OutVld !== 1'b0) begin errors++; $display("FAIL idle_vld got %b exp 0", OutVld); end
        checks++; if (OutId !== 2'd0 || OutData !== 10'h111) begin
            errors++; $display("FAIL idle_hold got id %0d data %h exp id 0 data 111", OutId, OutData);
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        ReqVld = 4'b1111;
        OutRdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (OutVld !== 1'b1 || OutId !== IW'(k % NREQ) || OutData !== dataTab[k % NREQ]) begin
                errors++;
                $display("FAIL rotate_%0d got vld %b id %0d data %h exp vld 1 id %0d data %h",
                         k, OutVld, OutId, OutData, k % NREQ, dataTab[k % NREQ]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        apply_reset();
        ReqVld = 4'b0010;
        OutRdy = 1'b1;
        step();
        checks++; if (OutId !== 2'd1) begin errors++; $display("FAIL bp_grant got %0d exp 1", OutId); end
        ReqVld = 4'b1111;
        OutRdy = 1'b0;
        #1;
        checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL bp_rdy got %b exp 0000", ReqRdy); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (OutVld !== 1'b1 || OutId !== 2'd1 || OutData !== 10'h2AA || ReqRdy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld %b id %0d data %h rdy %b exp vld 1 id 1 data 2aa rdy 0000",
                         k, OutVld, OutId, OutData, ReqRdy);
            end
        end
        checks++; if (StallCnt !== 16'd5) begin errors++; $display("FAIL bp_stallcnt got %0d exp 5", StallCnt); end
        OutRdy = 1'b1;
        #1;
        checks++; if (ReqRdy !== 4'b0100) begin errors++; $display("FAIL bp_release_rdy got %b exp 0100", ReqRdy); end
        step();
        checks++; if (OutId !== 2'd2) begin errors++; $display("FAIL bp_release_id got %0d exp 2", OutId); end
        checks++; if (StallCnt !== 16'd5) begin errors++; $display("FAIL bp_stall_keep got %0d exp 5", StallCnt); end
    endtask

    task automatic test_clear();
        OutRdy = 1'b0;
        step();
        checks++; if (StallCnt !== 16'd6) begin errors++; $display("FAIL clr_pre_stall got %0d exp 6", StallCnt); end
        Clear = 1'b1;
        #1;
        checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL clr_rdy_stall got %b exp 0000", ReqRdy); end
        OutRdy = 1'b1;
        #1;
        checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL clr_rdy_open got %b exp 0000", ReqRdy); end
        step();
        Clear = 1'b0;
        checks++; if (OutVld !== 1'b0) begin errors++; $display("FAIL clr_vld got %b exp 0", OutVld); end
        checks++; if (StallCnt !== '0) begin errors++; $display("FAIL clr_stall got %0d exp 0", StallCnt); end
        checks++; if (OutId !== 2'd2 || OutData !== 10'h055) begin
            errors++; $display("FAIL clr_hold got id %0d data %h exp id 2 data 055", OutId, OutData);
        end
        ReqVld = 4'b1010;
        #1;
        checks++; if (ReqRdy !== 4'b0010) begin errors++; $display("FAIL clr_ptr_rdy got %b exp 0010", ReqRdy); end
        step();
        checks++; if (OutId !== 2'd1 || OutVld !== 1'b1) begin
            errors++; $display("FAIL clr_ptr_id got id %0d vld %b exp id 1 vld 1", OutId, OutVld);
        end
    endtask

    task automatic test_async_reset();
        ReqVld = 4'b1111;
        OutRdy = 1'b1;
        repeat (2) step();
        OutRdy = 1'b0;
        repeat (2) step();
        checks++; if (StallCnt !== 16'd2) begin errors++; $display("FAIL ar_pre_stall got %0d exp 2", StallCnt); end
        #3;
        Rstn = 1'b0;
        #1;
        checks++; if (OutVld !== 1'b0) begin errors++; $display("FAIL ar_vld got %b exp 0", OutVld); end
        checks++; if (StallCnt !== '0) begin errors++; $display("FAIL ar_stall got %0d exp 0", StallCnt); end
        checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL ar_rdy got %b exp 0000", ReqRdy); end
        #2;
        Rstn   = 1'b1;
        OutRdy = 1'b1;
        #1;
        checks++; if (ReqRdy !== 4'b0001) begin errors++; $display("FAIL ar_first_rdy got %b exp 0001", ReqRdy); end
        step();
        checks++; if (OutId !== 2'd0 || OutVld !== 1'b1) begin
            errors++; $display("FAIL ar_first_id got id %0d vld %b exp id 0 vld 1", OutId, OutVld);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        ReqVld = 4'b0001;
        OutRdy = 1'b1;
        step();
        OutRdy = 1'b0;
        repeat (14) step();
        checks++; if (StallCnt4 !== 4'hE) begin errors++; $display("FAIL sat_14 got %h exp e", StallCnt4); end
        step();
        checks++; if (StallCnt4 !== 4'hF) begin errors++; $display("FAIL sat_15 got %h exp f", StallCnt4); end
        repeat (5) step();
        checks++; if (StallCnt4 !== 4'hF) begin errors++; $display("FAIL sat_20 got %h exp f", StallCnt4); end
        checks++; if (StallCnt !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", StallCnt); end
    endtask

    initial begin
        dataTab[0] = 10'h111;
        dataTab[1] = 10'h2AA;
        dataTab[2] = 10'h055;
        dataTab[3] = 10'h3C3;
        ReqData = {dataTab[3], dataTab[2], dataTab[1], dataTab[0]};
        ReqVld  = '0;
        OutRdy  = 1'b0;
        Clear   = 1'b0;
        Rstn    = 1'b0;
        test_reset();
        test_single_and_skip();
        test_rotation();
        test_back_to_back_stall();
        test_clear();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mid_pipe_rr_arb.md
Name: mid_pipe_rr_arb

Overview:
- Round-robin arbiter that shares one downstream pipe stage (valid/ready, DW-bit data) between NREQ upstream requesters.
- Picks one valid requester per accepted transfer and registers its data plus a source ID into a single output stage.
- Preserves full backpressure to every requester.
- Sits directly in front of the shared arithmetic stage; the ID travels with the data so results can be routed back.

Parameters:
NREQ, 4, number of requesters (2..16; need not be a power of 2)
DW, 10, data width per requester
IW, 2, source ID width; must satisfy 2**IW >= NREQ
SW, 16, stall counter width

Ports:
Clk  input  1  clock, rising edge
Rstn  input  1  reset, asynchronous, active-low
Clear  input  1  synchronous soft clear, active-high
ReqData  input  NREQ*DW  requester i data in bits [i*DW +: DW]
ReqVld  input  NREQ  per-requester valid
ReqRdy  output  NREQ  per-requester ready (one-hot or zero)
OutData  output  DW  registered data of the granted requester
OutId  output  IW  registered index of the granted requester
OutVld  output  1  output valid
OutRdy  input  1  downstream ready
StallCnt  output  SW  saturating count of backpressure cycles

Behaviour:
- Reset (Rstn=0, async): OutData=0, OutId=0, OutVld=0, priority pointer ptr=0, StallCnt=0.
  - ReqRdy is 0 while in reset.
- Load enable (combinational): load = (OutRdy | ~OutVld) & ~Clear.
- Winner (combinational): the first index i with ReqVld[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - No winner when ReqVld=0.
- ReqRdy[i] = load & (i == winner) & ReqVld[i]. At most one bit is set.
  - ReqRdy does not depend on OutRdy beyond load. No combinational path from OutRdy exists except through load.
- Transfer: on a clock edge with load=1 and a winner w:
  - OutData <= ReqData[w]
  - OutId <= w
  - OutVld <= 1
  - ptr <= (w == NREQ-1) ? 0 : w+1
- Clock edge with load=1 and no winner: OutVld <= 0. OutData, OutId and ptr hold.
- Clock edge with load=0 (stalled, OutVld=1, OutRdy=0): all registers hold.
  - The grant cannot change while stalled; the requester's data is not consumed.
- Latency: 1 cycle from the request handshake to OutVld.
- Throughput: 1 transfer/cycle while OutRdy=1. Back-to-back transfers with no bubble.
- Fairness: with all NREQ requesters continuously valid, grants rotate strictly, so each requester waits at most NREQ-1 transfers.
- Clear=1 (synchronous): OutVld <= 0, ptr <= 0, StallCnt <= 0; ReqRdy=0 that cycle.
  - OutData and OutId hold.
  - Clear takes priority over every other update.
- StallCnt: increments on each edge where OutVld=1 and OutRdy=0 and Clear=0. It saturates at all-ones and does not wrap.
- Pointer wrap: ptr never takes a value >= NREQ, including when NREQ is not a power of 2.
- Reset mid-operation: OutVld drops immediately (async). Any in-flight output beat is lost; requesters must resend.
- Requesters must hold ReqData/ReqVld stable until ReqRdy; the arbiter does not check this.

Test Plan:
- Single requester: NREQ=4, ReqVld=4'b0100, ReqData[2]=10'h055, OutRdy=1 -> next cycle OutVld=1, OutData=10'h055, OutId=2; ptr becomes 3.
- All valid, OutRdy=1 for 8 cycles from reset -> OutId sequence 0,1,2,3,0,1,2,3, with no bubbles on OutVld.
- Backpressure: grant requester 1, then OutRdy=0 for 5 cycles while ReqVld=4'b1111 -> ReqRdy=0, OutData/OutId hold, StallCnt=5. OutRdy=1 -> next OutId=2.
- Skip idle requesters: ptr=3, ReqVld=4'b0010 -> winner 1, ptr becomes 2. Then ReqVld=4'b0001 -> winner 0.
- Clear during stall: OutVld=1, OutRdy=0, Clear pulse 1 cycle -> OutVld=0, StallCnt=0, ptr=0, ReqRdy=0 that cycle. Next cycle with ReqVld=4'b1010 -> OutId=1.
- Async reset mid-stream: Rstn low mid-cycle during continuous traffic -> OutVld=0 immediately, StallCnt=0. After release with ReqVld=4'b1111, first OutId=0. StallCnt saturation (SW=4, 20 stall cycles) -> StallCnt=4'hF.
